// File: rtl/timekeeping_pkg.sv
// Shared timekeeping definitions: field widths, field limits and the countdown state set.
// Used by both the time-of-day clock and the countdown timer so their outputs line up.
package timekeeping_pkg;

  localparam int HOURS_W = 5;
  localparam int MIN_W   = 6;
  localparam int SEC_W   = 6;

  localparam logic [HOURS_W-1:0] MAX_HOURS   = 5'd23;
  localparam logic [MIN_W-1:0]   MAX_MINUTES = 6'd59;
  localparam logic [SEC_W-1:0]   MAX_SECONDS = 6'd59;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } timer_state_t;

  function automatic logic timeInRange(
    input logic [HOURS_W-1:0] h,
    input logic [MIN_W-1:0]   m,
    input logic [SEC_W-1:0]   s
  );
    return (h <= MAX_HOURS) && (m <= MAX_MINUTES) && (s <= MAX_SECONDS);
  endfunction

endpackage

// File: rtl/countdown_prescaler.sv
// Divides the system clock down to a one-second tick.
// Counts only while enabled and wraps on the tick; clear restarts the second from zero.
module countdown_prescaler #(
  parameter int CLKS_PER_SEC = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_SEC - 1);

  logic [CW-1:0] r_count;

  assign tick = enable && (r_count == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (tick) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/countdown_timer_24hr.sv
// Loadable hh:mm:ss countdown timer with run/pause control and expiry flagging.
// Strobes resolve as load > start > pause; every output comes straight from a register.
module countdown_timer_24hr
  import timekeeping_pkg::*;
#(
  parameter int CLKS_PER_SEC = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [HOURS_W-1:0] load_hours,
  input  logic [MIN_W-1:0]   load_minutes,
  input  logic [SEC_W-1:0]   load_seconds,
  input  logic               start,
  input  logic               pause,
  output logic [HOURS_W-1:0] hours,
  output logic [MIN_W-1:0]   minutes,
  output logic [SEC_W-1:0]   seconds,
  output logic               running,
  output logic               done,
  output logic               expired,
  output logic               load_err
);

  timer_state_t       r_state;
  logic [HOURS_W-1:0] r_hours;
  logic [MIN_W-1:0]   r_minutes;
  logic [SEC_W-1:0]   r_seconds;
  logic               r_running;
  logic               r_done;
  logic               r_expired;
  logic               r_loadErr;

  logic               w_loadValid;
  logic               w_loadBad;
  logic               w_startEff;
  logic               w_pauseEff;
  logic               w_timeNonZero;
  logic               w_startOk;
  logic               w_countEnable;
  logic               w_prescaleClear;
  logic               w_tick;
  logic               w_hitZero;
  logic [HOURS_W-1:0] w_decHours;
  logic [MIN_W-1:0]   w_decMinutes;
  logic [SEC_W-1:0]   w_decSeconds;
  timer_state_t       w_nextState;
  logic [HOURS_W-1:0] w_nextHours;
  logic [MIN_W-1:0]   w_nextMinutes;
  logic [SEC_W-1:0]   w_nextSeconds;
  logic               w_nextDone;

  assign w_loadValid   = load && timeInRange(load_hours, load_minutes, load_seconds);
  assign w_loadBad     = load && !timeInRange(load_hours, load_minutes, load_seconds);
  assign w_startEff    = !load && start;
  assign w_pauseEff    = !load && !start && pause;
  assign w_timeNonZero = (r_hours != '0) || (r_minutes != '0) || (r_seconds != '0);
  assign w_startOk     = w_startEff && w_timeNonZero && ((r_state == IDLE) || (r_state == PAUSED));

  // A valid load or an accepted pause freezes the second in progress.
  assign w_countEnable   = (r_state == RUN) && !w_loadValid && !w_pauseEff;
  assign w_prescaleClear = w_loadValid || (w_startOk && (r_state == IDLE));

  countdown_prescaler #(
    .CLKS_PER_SEC(CLKS_PER_SEC)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .enable(w_countEnable),
    .clear (w_prescaleClear),
    .tick  (w_tick)
  );

  // Borrow chain; hours cannot underflow since RUN is never entered at zero.
  always_comb begin
    w_decHours   = r_hours;
    w_decMinutes = r_minutes;
    w_decSeconds = r_seconds - SEC_W'(1);
    if (r_seconds == '0) begin
      w_decSeconds = MAX_SECONDS;
      if (r_minutes == '0) begin
        w_decMinutes = MAX_MINUTES;
        w_decHours   = r_hours - HOURS_W'(1);
      end else begin
        w_decMinutes = r_minutes - MIN_W'(1);
      end
    end
  end

  assign w_hitZero = (r_hours == '0) && (r_minutes == '0) && (r_seconds == SEC_W'(1));

  always_comb begin
    w_nextState   = r_state;
    w_nextHours   = r_hours;
    w_nextMinutes = r_minutes;
    w_nextSeconds = r_seconds;
    w_nextDone    = 1'b0;
    if (w_loadValid) begin
      w_nextState   = IDLE;
      w_nextHours   = load_hours;
      w_nextMinutes = load_minutes;
      w_nextSeconds = load_seconds;
    end else if (w_startOk) begin
      w_nextState = RUN;
    end else if (w_pauseEff && (r_state == RUN)) begin
      w_nextState = PAUSED;
    end else if (w_tick) begin
      w_nextHours   = w_decHours;
      w_nextMinutes = w_decMinutes;
      w_nextSeconds = w_decSeconds;
      if (w_hitZero) begin
        w_nextState = EXPIRED;
        w_nextDone  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_hours   <= '0;
      r_minutes <= '0;
      r_seconds <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_expired <= 1'b0;
      r_loadErr <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_hours   <= w_nextHours;
      r_minutes <= w_nextMinutes;
      r_seconds <= w_nextSeconds;
      r_running <= (w_nextState == RUN);
      r_done    <= w_nextDone;
      r_expired <= (w_nextState == EXPIRED);
      r_loadErr <= w_loadBad;
    end
  end

  assign hours    = r_hours;
  assign minutes  = r_minutes;
  assign seconds  = r_seconds;
  assign running  = r_running;
  assign done     = r_done;
  assign expired  = r_expired;
  assign load_err = r_loadErr;

endmodule

// File: tb/tb_countdown_timer_24hr.sv
// Directed self-checking bench for countdown_timer_24hr with one decrement per running cycle.
// Expected values are hand-computed; flags are packed as {running, done, expired, load_err}.
module tb_countdown_timer_24hr;

  logic       clk;
  logic       reset;
  logic       load;
  logic [4:0] loadHours;
  logic [5:0] loadMinutes;
  logic [5:0] loadSeconds;
  logic       start;
  logic       pause;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       running;
  logic       done;
  logic       expired;
  logic       loadErr;

  int checks   = 0;
  int failures = 0;

  countdown_timer_24hr #(
    .CLKS_PER_SEC(1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .load_hours  (loadHours),
    .load_minutes(loadMinutes),
    .load_seconds(loadSeconds),
    .start       (start),
    .pause       (pause),
    .hours       (hours),
    .minutes     (minutes),
    .seconds     (seconds),
    .running     (running),
    .done        (done),
    .expired     (expired),
    .load_err    (loadErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle of strobes, clocks it in, and leaves the bench 1ns after the edge.
  task automatic applyStimulus(input logic ld, input logic [4:0] h, input logic [5:0] m,
                               input logic [5:0] s, input logic st, input logic pa);
    load        = ld;
    loadHours   = h;
    loadMinutes = m;
    loadSeconds = s;
    start       = st;
    pause       = pa;
    @(posedge clk);
    #1;
    load  = 1'b0;
    start = 1'b0;
    pause = 1'b0;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 5'd0, 6'd0, 6'd0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkTime(input string tag, input int h, input int m, input int s);
    checkOutput({tag, " time"}, {15'd0, hours, minutes, seconds},
                {15'd0, h[4:0], m[5:0], s[5:0]});
  endtask

  task automatic checkFlags(input string tag, input logic r, input logic d, input logic e, input logic le);
    checkOutput({tag, " flags"}, {28'd0, running, done, expired, loadErr}, {28'd0, r, d, e, le});
  endtask

  initial begin
    reset = 1'b0;
    load = 1'b0; start = 1'b0; pause = 1'b0;
    loadHours = '0; loadMinutes = '0; loadSeconds = '0;

    // Reset state and a quiet stretch after release
    repeat (2) @(posedge clk);
    #1;
    checkTime("in_reset", 0, 0, 0);
    checkFlags("in_reset", 0, 0, 0, 0);
    reset = 1'b1;
    repeat (20) idleCycle();
    checkTime("quiet20", 0, 0, 0);
    checkFlags("quiet20", 0, 0, 0, 0);
    applyStimulus(1'b0, 5'd0, 6'd0, 6'd0, 1'b1, 1'b0);
    checkFlags("start_at_zero", 0, 0, 0, 0);
    idleCycle();
    checkTime("start_at_zero_after", 0, 0, 0);
    checkFlags("start_at_zero_after", 0, 0, 0, 0);

    // 0:0:3 countdown to expiry
    applyStimulus(1'b1, 5'd0, 6'd0, 6'd3, 1'b0, 1'b0);
    checkTime("load003", 0, 0, 3);
    checkFlags("load003", 0, 0, 0, 0);
    applyStimulus(1'b0, 5'd0, 6'd0, 6'd0, 1'b1, 1'b0);
    checkTime("start003", 0, 0, 3);
    checkFlags("start003", 1, 0, 0, 0);
    idleCycle();
    checkTime("cnt2", 0, 0, 2);
    checkFlags("cnt2", 1, 0, 0, 0);
    idleCycle();
    checkTime("cnt1", 0, 0, 1);
    idleCycle();
    checkTime("cnt0", 0, 0, 0);
    checkFlags("cnt0", 0, 1, 1, 0);
    idleCycle();
    checkTime("after_done", 0, 0, 0);
    checkFlags("after_done", 0, 0, 1, 0);
    applyStimulus(1'b0, 5'd0, 6'd0, 6'd0, 1'b1, 1'b0);
    checkFlags("start_in_expired", 0, 0, 1, 0);

    // Double borrow from 1:00:00
    applyStimulus(1'b1, 5'd1, 6'd0, 6'd0, 1'b0, 1'b0);
    checkFlags("load100", 0, 0, 0, 0);
    applyStimulus(1'b0, 5'd0, 6'd0, 6'd0, 1'b1, 1'b0);
    idleCycle();
    checkTime("borrow1", 0, 59, 59);
    idleCycle();
    checkTime("borrow2", 0, 59, 58);
    checkFlags("borrow2", 1, 0, 0, 0);

    // 23:59:59, pause hold, resume
    applyStimulus(1'b1, 5'd23, 6'd59, 6'd59, 1'b0, 1'b0);
    checkTime("load235959", 23, 59, 59);
    applyStimulus(1'b0, 5'd0, 6'd0, 6'd0, 1'b1, 1'b0);
    repeat (5) idleCycle();
    checkTime("five_ticks", 23, 59, 54);
    applyStimulus(1'b0, 5'd0, 6'd0, 6'd0, 1'b0, 1'b1);
    checkTime("paused", 23, 59, 54);
    checkFlags("paused", 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      idleCycle();
      checkTime("pause_hold", 23, 59, 54);
    end
    checkFlags("pause_hold", 0, 0, 0, 0);
    applyStimulus(1'b0, 5'd0, 6'd0, 6'd0, 1'b1, 1'b0);
    checkTime("resume_edge", 23, 59, 54);
    checkFlags("resume_edge", 1, 0, 0, 0);
    idleCycle();
    checkTime("resumed", 23, 59, 53);

    // Out-of-range loads while running
    applyStimulus(1'b1, 5'd24, 6'd0, 6'd0, 1'b0, 1'b0);
    checkTime("bad_hours", 23, 59, 52);
    checkFlags("bad_hours", 1, 0, 0, 1);
    idleCycle();
    checkTime("bad_hours_after", 23, 59, 51);
    checkFlags("bad_hours_after", 1, 0, 0, 0);
    applyStimulus(1'b1, 5'd0, 6'd60, 6'd0, 1'b0, 1'b0);
    checkTime("bad_minutes", 23, 59, 50);
    checkFlags("bad_minutes", 1, 0, 0, 1);
    idleCycle();
    checkFlags("bad_minutes_after", 1, 0, 0, 0);

    // Load beats pause in the same cycle
    applyStimulus(1'b1, 5'd0, 6'd0, 6'd5, 1'b0, 1'b1);
    checkTime("load_vs_pause", 0, 0, 5);
    checkFlags("load_vs_pause", 0, 0, 0, 0);
    idleCycle();
    checkTime("load_vs_pause_hold", 0, 0, 5);

    // Asynchronous reset mid-run
    applyStimulus(1'b0, 5'd0, 6'd0, 6'd0, 1'b1, 1'b0);
    idleCycle();
    checkTime("pre_reset", 0, 0, 4);
    #2;
    reset = 1'b0;
    #1;
    checkTime("async_reset", 0, 0, 0);
    checkFlags("async_reset", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) idleCycle();
    checkTime("post_reset", 0, 0, 0);
    checkFlags("post_reset", 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/countdown_timer_24hr.md
Name: countdown_timer_24hr

Overview:
Down-counting counterpart of the team's 24-hour up-counting time-of-day clock. It is loaded with an hh:mm:ss value, counts down once per second on start, and flags expiry at 00:00:00. Its time outputs use the same widths and ranges as the time-of-day clock, so both blocks feed the same display and compare logic. It sits beside the clock in the timekeeping subsystem as the alarm/kitchen-timer engine.

Parameters:
- CLKS_PER_SEC, default 1: clk cycles per one-second decrement; must be >= 1. The value 1 means one decrement per RUN cycle, for simulation.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (reset==0 resets).
- load  input  1  one-cycle strobe; captures load_hours/minutes/seconds.
- load_hours  input  5  preset hours, valid 0..23.
- load_minutes  input  6  preset minutes, valid 0..59.
- load_seconds  input  6  preset seconds, valid 0..59.
- start  input  1  one-cycle strobe; begin or resume counting.
- pause  input  1  one-cycle strobe; freeze counting.
- hours  output  5  current remaining hours.
- minutes  output  6  current remaining minutes.
- seconds  output  6  current remaining seconds.
- running  output  1  high while in RUN.
- done  output  1  one-cycle pulse on reaching 00:00:00 from RUN.
- expired  output  1  level; high in EXPIRED.
- load_err  output  1  one-cycle pulse; load rejected as out of range.

Behaviour:
- Reset (async assert, sync release): hours=minutes=seconds=0; state IDLE; prescaler=0; running=done=expired=load_err=0.
- States:
  - IDLE: loaded, not counting.
  - RUN: counting.
  - PAUSED: frozen mid-count.
  - EXPIRED: reached zero.
- Strobe priority within one cycle: load > start > pause. Lower-priority strobes in the same cycle are ignored.
- load with all fields in range:
  - Accepted in any state.
  - Time registers take the load values at that edge.
  - State goes to IDLE and prescaler is cleared.
- load with any field out of range:
  - load_err=1 for the next cycle.
  - Time, state and prescaler are unchanged.
- start:
  - From IDLE or PAUSED with time != 0: go to RUN. From IDLE the prescaler is cleared; from PAUSED it is held.
  - With time == 0, from EXPIRED, or while already in RUN: ignored.
- pause: RUN -> PAUSED. Ignored in all other states.
- Prescaler:
  - Counts 0..CLKS_PER_SEC-1, advancing only in RUN.
  - tick fires when prescaler==CLKS_PER_SEC-1 in RUN; the prescaler wraps to 0 on tick.
- Latency: start sampled at edge N gives running=1 after edge N; first decrement at edge N+CLKS_PER_SEC.
- Decrement on tick:
  - seconds>0: seconds-1.
  - seconds==0: seconds=59 and borrow from minutes.
  - minutes==0 on borrow: minutes=59 and borrow from hours.
  - Hours never underflow, because RUN is never entered at zero.
- Expiry: the tick that makes the time 00:00:00 moves the state to EXPIRED on the same edge. done=1 and expired=1 are visible in the same cycle that the outputs show 0:0:0. done drops the following cycle; expired holds.
- EXPIRED is left only via a valid load (to IDLE) or reset.
- pause and tick in the same cycle: pause wins. No decrement occurs and the prescaler holds.
- All outputs are registered. Values are never outside 0..23 / 0..59.
- Reset asserted mid-count returns everything to reset values immediately, with no done pulse.

Decomposition:
- Shared package timekeeping_pkg:
  - constants MAX_HOURS=23, MAX_MINUTES=59, MAX_SECONDS=59;
  - width constants HOURS_W=5, MIN_W=6, SEC_W=6;
  - state enum {IDLE, RUN, PAUSED, EXPIRED}.
- One sub-module, countdown_prescaler:
  - parameter CLKS_PER_SEC;
  - inputs enable and clear;
  - output tick;
  - asynchronous active-low reset.
- The decrement/borrow logic and the FSM stay in the top module.

Test Plan:
- Reset release, no strobes for 20 cycles -> outputs 0:0:0; running=expired=done=load_err=0; start with 0:0:0 is ignored.
- load 0:0:3, start (CLKS_PER_SEC=1):
  - seconds reads 2, 1, 0 on the three edges after start;
  - done=1 for exactly the cycle showing 0, then 0;
  - expired stays 1;
  - running falls in that same cycle.
- load 1:0:0, start, one tick -> 0:59:59, then 0:59:58; confirms double borrow.
- load 23:59:59, start, 5 ticks -> 23:59:54; pause -> values hold for 10 cycles with running=0; start -> resumes at 23:59:53 on the next tick.
- load 24:00:00 or 0:60:00 while in RUN -> load_err pulse of 1 cycle; time keeps counting; state stays RUN.
- Mid-RUN, pause and load 0:0:5 in the same cycle -> load wins: IDLE at 0:0:5, no decrement. Separately, reset asserted mid-RUN -> immediate 0:0:0, IDLE, no done pulse.
